// File: rtl/regfile.sv
// Multi-ported register file: combinational reads, clocked writes, optional hardwired r0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
`timescale 1ns/1ps
module regfile #(
    parameter int DATA     = 32,
    parameter int ADDR     = 5,
    parameter int READ     = 4,
    parameter int WRITE    = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [ADDR*READ-1:0]  raddr,
    output logic [DATA*READ-1:0]  rdata,
    input  logic [ADDR*WRITE-1:0] waddr,
    input  logic [DATA*WRITE-1:0] wdata,
    input  logic [WRITE-1:0]      we_
);

    localparam int DEPTH = 2**ADDR;

    logic [DATA-1:0] regs [0:DEPTH-1];

    // Ascending port order so the highest-index port's write lands last.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < WRITE; j++) begin
                if (!we_[j] && !((ZERO_REG != 0) && (waddr[j*ADDR +: ADDR] == '0))) begin
                    regs[waddr[j*ADDR +: ADDR]] <= wdata[j*DATA +: DATA];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < READ; i++) begin
            rdata[i*DATA +: DATA] = regs[raddr[i*ADDR +: ADDR]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed under reset so rdata reads all-zero then.
            for (int j = 0; j < WRITE; j++) begin
                if (reset_ && !we_[j] && (waddr[j*ADDR +: ADDR] == raddr[i*ADDR +: ADDR])) begin
                    rdata[i*DATA +: DATA] = wdata[j*DATA +: DATA];
                end
            end
`endif
            if ((ZERO_REG != 0) && (raddr[i*ADDR +: ADDR] == '0)) begin
                rdata[i*DATA +: DATA] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Randomized self-checking bench for regfile against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile;

    localparam int DATA     = 32;
    localparam int ADDR     = 5;
    localparam int READ     = 4;
    localparam int WRITE    = 4;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 2**ADDR;

    logic                  clk = 1'b0;
    logic                  reset_;
    logic [ADDR*READ-1:0]  raddr;
    logic [DATA*READ-1:0]  rdata;
    logic [ADDR*WRITE-1:0] waddr;
    logic [DATA*WRITE-1:0] wdata;
    logic [WRITE-1:0]      we_;

    logic [DATA-1:0] model [0:DEPTH-1];
    int n_tests = 0;
    int n_fail  = 0;

    regfile #(.DATA(DATA), .ADDR(ADDR), .READ(READ), .WRITE(WRITE), .ZERO_REG(ZERO_REG)) dut (
        .clk(clk), .reset_(reset_), .raddr(raddr), .rdata(rdata),
        .waddr(waddr), .wdata(wdata), .we_(we_)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA-1:0] exp_read(input int a);
        if (!reset_) return '0;
        if (ZERO_REG != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        for (int j = WRITE-1; j >= 0; j--)
            if (!we_[j] && int'(waddr[j*ADDR +: ADDR]) == a) return wdata[j*DATA +: DATA];
`endif
        return model[a];
    endfunction

    task automatic check_reads(input string tag);
        for (int i = 0; i < READ; i++)
            chk($sformatf("%s_p%0d_a%0d", tag, i, raddr[i*ADDR +: ADDR]),
                rdata[i*DATA +: DATA], exp_read(int'(raddr[i*ADDR +: ADDR])));
    endtask

    task automatic model_write();
        if (reset_) begin
            for (int j = 0; j < WRITE; j++) begin
                int a;
                a = int'(waddr[j*ADDR +: ADDR]);
                if (!we_[j] && !(ZERO_REG != 0 && a == 0)) model[a] = wdata[j*DATA +: DATA];
            end
        end
    endtask

    task automatic set_w(input int j, input int a, input logic [DATA-1:0] d);
        waddr[j*ADDR +: ADDR] = ADDR'(a);
        wdata[j*DATA +: DATA] = d;
    endtask

    task automatic set_r(input int i, input int a);
        raddr[i*ADDR +: ADDR] = ADDR'(a);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic do_cycle(input string tag);
        #1 check_reads({tag, "_pre"});
        @(posedge clk);
        model_write();
        #1 check_reads({tag, "_post"});
        @(negedge clk);
    endtask

    task automatic read_all(input string tag);
        we_ = '1;
        for (int base = 0; base < DEPTH; base += READ) begin
            for (int i = 0; i < READ; i++) set_r(i, base + i);
            #1 check_reads(tag);
        end
    endtask

    task automatic randomize_inputs();
        for (int j = 0; j < WRITE; j++)
            set_w(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1), $urandom);
        for (int i = 0; i < READ; i++) set_r(i, $urandom_range(0, DEPTH-1));
        we_ = WRITE'($urandom);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        reset_ = 1'b0;
        raddr  = '0;
        randomize_inputs();
        we_ = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        read_all("reset");
        reset_ = 1'b1;
        read_all("after_reset");

        @(negedge clk);
        set_w(0, 31, 31); set_w(1, 1, 1); set_w(2, 2, 2); set_w(3, 3, 3);
        we_ = 4'b0000;
        do_cycle("par");
        we_ = '1;
        set_r(0, 31); set_r(1, 1); set_r(2, 2); set_r(3, 3);
        #1;
        chk("par_r31", rdata[0*DATA +: DATA], 31);
        chk("par_r1",  rdata[1*DATA +: DATA], 1);
        chk("par_r2",  rdata[2*DATA +: DATA], 2);
        chk("par_r3",  rdata[3*DATA +: DATA], 3);
        @(negedge clk);

        set_w(0, 0, 32'hdeadbeef);
        we_ = 4'b1110;
        set_r(0, 0);
        do_cycle("zero");
        we_ = '1;
        #1 chk("zero_r0", rdata[0*DATA +: DATA], 0);
        @(negedge clk);

        set_r(0, 2); set_r(1, 3); set_r(2, 1); set_r(3, 31);
        set_w(0, 4, 32'h10); set_w(1, 5, 32'h20); set_w(2, 6, 32'h30); set_w(3, 31, 31);
        we_ = 4'b0000;
        do_cycle("rww");
        we_ = '1;
        set_r(0, 4); set_r(1, 5); set_r(2, 6); set_r(3, 31);
        #1;
        chk("rww_r4",  rdata[0*DATA +: DATA], 32'h10);
        chk("rww_r5",  rdata[1*DATA +: DATA], 32'h20);
        chk("rww_r6",  rdata[2*DATA +: DATA], 32'h30);
        chk("rww_r31", rdata[3*DATA +: DATA], 31);
        @(negedge clk);

        set_w(0, 7, 5); set_w(3, 7, 9);
        we_ = 4'b0110;
        do_cycle("conflict");
        we_ = '1;
        set_r(0, 7);
        #1 chk("conflict_r7", rdata[0*DATA +: DATA], 9);
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            do_cycle($sformatf("rand%0d", c));
        end
        read_all("rand_final");

        @(negedge clk);
        randomize_inputs();
        we_ = 4'b0000;
        #2 reset_ = 1'b0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        #0.5 check_reads("async_rst_imm");
        read_all("async_rst");
        @(negedge clk);
        reset_ = 1'b1;

        for (int c = 0; c < 100; c++) begin
            randomize_inputs();
            do_cycle($sformatf("post%0d", c));
        end
        read_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
